// File: rtl/sdram_burst_reader.sv
// Burst-read sequencer for SDRAM controller channel 2: turns one (address, length)
// command into single-word reads, one outstanding, buffered in a FWFT FIFO.
module sdram_burst_reader #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [26:0] cmd_addr,
   input  logic [7:0]  cmd_len,
   output logic [26:0] ch2_addr,
   output logic        ch2_req,
   output logic        ch2_rnw,
   output logic [31:0] ch2_din,
   input  logic [31:0] ch2_dout,
   input  logic        ch2_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [1:0]  state_dbg
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [26:0]        addr_q, addr_d;
   logic [26:0]        ch2_addr_q, ch2_addr_d;
   logic               ch2_req_q, ch2_req_d;
   logic [8:0]         remaining_q, remaining_d;
   logic [31:0]        mem_q [FIFO_DEPTH];
   logic [31:0]        mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push, pop, fifo_empty, fifo_has_room;
   logic               unused_addr_lsbs;

   assign unused_addr_lsbs = ^cmd_addr[1:0];

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ch2_addr_d  = ch2_addr_q;
      ch2_req_d   = 1'b0;
      remaining_d = remaining_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      fifo_empty    = (count_q == '0);
      fifo_has_room = (count_q < DEPTH_C);
      // Only a completion for our own outstanding request may push.
      push          = (state_q == S_WAIT) && ch2_ready;
      pop           = !fifo_empty && out_ready;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d      = {cmd_addr[26:2], 2'b00};
               remaining_d = {1'b0, cmd_len} + 9'd1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (fifo_has_room) begin
               ch2_req_d  = 1'b1;
               ch2_addr_d = addr_q;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (ch2_ready) begin
               addr_d      = addr_q + 27'd4;
               remaining_d = remaining_q - 9'd1;
               state_d     = (remaining_q == 9'd1) ? S_DRAIN : S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (fifo_empty) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = ch2_dout;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         ch2_addr_q  <= '0;
         ch2_req_q   <= 1'b0;
         remaining_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ch2_addr_q  <= ch2_addr_d;
         ch2_req_q   <= ch2_req_d;
         remaining_q <= remaining_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // done marks the DRAIN cycle that finds the FIFO empty; busy is already low there.
   assign done      = (state_q == S_DRAIN) && fifo_empty;
   assign busy      = (state_q != S_IDLE) && !done;
   assign cmd_ready = (state_q == S_IDLE) && !reset;
   assign ch2_req   = ch2_req_q;
   assign ch2_addr  = ch2_addr_q;
   assign ch2_rnw   = 1'b1;
   assign ch2_din   = 32'd0;
   assign out_valid = !fifo_empty;
   assign out_data  = mem_q[rd_ptr_q];
   assign state_dbg = state_q;
endmodule

// File: doc/sdram_burst_reader.md
# sdram_burst_reader

Upstream sequencer for the SDRAM controller's 32-bit channel 2. It accepts one burst-read command (start address, word count) and issues consecutive single-word channel-2 read requests, keeping at most one outstanding. Returned words go into a small first-word-fall-through FIFO, which drains over a valid/ready stream to the consuming client (e.g. a DMA or RDP fetch stage). FIFO credit throttles request issue, so returned data is never dropped.

## Interface
- FIFO_DEPTH, 4 — read-data FIFO entries; power of two, 2..16.
- clk  in  1  controller clock, same clock as the SDRAM controller.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  burst command present.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  27  byte start address; bits [1:0] ignored (forced 0).
- cmd_len  in  8  word count minus one (1..256 words).
- ch2_addr  out  27  address to controller channel 2.
- ch2_req  out  1  single-cycle request pulse.
- ch2_rnw  out  1  constant 1 (read).
- ch2_din  out  32  constant 0.
- ch2_dout  in  32  read data; valid in the cycle ch2_ready is high.
- ch2_ready  in  1  single-cycle completion pulse from the controller.
- out_valid  out  1  FIFO non-empty.
- out_data  out  32  FIFO head word.
- out_ready  in  1  consumer pop; pop when out_valid & out_ready.
- busy  out  1  high from command accept until the last word is popped.
- done  out  1  one-cycle pulse in the cycle busy falls.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE: cmd_ready=1. On accept: addr <= {cmd_addr[26:2],2'b00}, remaining <= cmd_len+1 (9-bit), busy <= 1, state <= ISSUE.
- ISSUE: if fifo_count < FIFO_DEPTH, then ch2_req <= 1 (one cycle), ch2_addr <= addr, state <= WAIT. Otherwise hold in ISSUE, with no request.
- WAIT: on ch2_ready, push ch2_dout, addr <= addr+4 (27-bit, wraps 0x7FFFFFC→0), remaining <= remaining-1. Next state is DRAIN if remaining was 1, else ISSUE.
- DRAIN: when FIFO empty and no pop pending: busy <= 0, done <= 1, state <= IDLE.
- ch2_ready outside WAIT is ignored: no push, no state change.
- FIFO: circular buffer with pointers of log2(FIFO_DEPTH) bits and a count of log2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
  - Push is never attempted when full; guaranteed by the ISSUE check with a single outstanding request.
  - Pop while empty is ignored.
- Words leave in address order. out_data is stable while out_valid & ~out_ready.
- cmd_valid outside IDLE is ignored (not queued).
- Reset values:
  - state=IDLE, cmd_ready=1 after the reset cycle (0 during reset).
  - ch2_req=0, ch2_addr=0, ch2_rnw=1, ch2_din=0.
  - FIFO empty, out_valid=0, busy=0, done=0.
- Reset mid-burst: all state is discarded, FIFO flushed. A ch2_ready for the abandoned request that arrives after reset is ignored by the IDLE rule.

## Timing
- Cycle 0: command accepted. Cycle 1: ISSUE. Cycle 2: ch2_req high with ch2_addr valid.
- ch2_ready at cycle k: word visible on out_valid/out_data at k+1. ISSUE at k+1, next ch2_req at k+2 (earliest). Per-word overhead beyond controller latency: 2 cycles.
- Last ch2_ready at k with the consumer always ready: DRAIN at k+1, word popped at k+1. FIFO is empty at k+2, so busy falls and done pulses at k+2; cmd_ready is high at k+3.
- ch2_req is never high in two consecutive cycles. Exactly cmd_len+1 pulses per command.

## Test plan
- Single word: addr=0x0000100, len=0, controller returns 0xDEADBEEF → one ch2_req at addr 0x100; out_data=0xDEADBEEF; done pulses once; exactly one request.
- 8-word burst, out_ready=1: addr=0x0001000 → ch2_addr sequence 0x1000,0x1004,…,0x101C; 8 words out in order; done after the 8th pop.
- Backpressure: len=9, out_ready=0 → exactly FIFO_DEPTH (4) requests, then stall in ISSUE. Release out_ready: remaining 6 requests issue; all 10 words in order, none lost or duplicated.
- Wrap: addr=0x7FFFFF8, len=3 → ch2_addr 0x7FFFFF8, 0x7FFFFFC, 0x0000000, 0x0000004.
- Reset in WAIT with a request outstanding; controller then pulses ch2_ready → no push, out_valid stays 0, cmd_ready=1. A new command then runs normally.
- Stray ch2_ready in IDLE and cmd_valid while busy → both ignored; the in-flight burst count and data are unchanged.
